bsg_fsb_node_client_mc: RTL

Multi-channel, credit-flow-controlled FSB node client that connects one FSB ring attachment to channels_p independent node-side endpoints.
- Ingress: demuxes FSB packets by a channel field into per-channel buffered queues.
- Egress: round-robin arbitrates among channel sources into one registered FSB output, gated by a remote-credit counter.
- Generalises the single-channel, fixed-buffer client in width, queue depth, channel count and credit depth.

---
 rtl/bsg_fsb_node_client_mc.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bsg_fsb_node_client_mc.sv
// Multi-channel credit-flow-controlled FSB node client: channel-demuxed ingress queues, round-robin egress.
// Optional statistics counters enabled by defining BSG_FSB_CLIENT_STATS_EN.
module bsg_fsb_node_client_mc #(
    parameter int unsigned width_p          = 80,
    parameter int unsigned channels_p       = 4,
    parameter int unsigned chan_lsb_p       = 0,
    parameter int unsigned fifo_els_p       = 4,
    parameter int unsigned remote_credits_p = 128
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    en_i,
    input  logic                                    fsb_v_i,
    input  logic [width_p-1:0]                      fsb_data_i,
    output logic                                    fsb_ready_o,
    output logic [channels_p-1:0]                   node_v_o,
    output logic [channels_p*width_p-1:0]           node_data_o,
    input  logic [channels_p-1:0]                   node_yumi_i,
    input  logic [channels_p-1:0]                   node_v_i,
    input  logic [channels_p*width_p-1:0]           node_data_i,
    output logic [channels_p-1:0]                   node_yumi_o,
    output logic                                    fsb_v_o,
    output logic [width_p-1:0]                      fsb_data_o,
    input  logic                                    fsb_yumi_i,
    input  logic                                    credit_v_i,
    output logic [$clog2(remote_credits_p+1)-1:0]   credits_o,
    output logic                                    err_o,
    output logic [31:0]                             stat_rx_o,
    output logic [31:0]                             stat_tx_o,
    output logic [31:0]                             stat_stall_o
);

    localparam int unsigned cw  = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int unsigned crw = $clog2(remote_credits_p + 1);
    localparam int unsigned pw  = $clog2(fifo_els_p);
    localparam int unsigned nw  = $clog2(fifo_els_p + 1);
    localparam logic [cw:0]     chan_lim = (cw+1)'(channels_p);
    localparam logic [crw-1:0]  cred_max = crw'(remote_credits_p);
    localparam logic [pw-1:0]   last_ptr = pw'(fifo_els_p - 1);

    logic [cw-1:0]         sel;
    logic                  sel_valid, full_sel, accept, drop, overflow;
    logic [channels_p-1:0] full, enq;

    assign sel       = fsb_data_i[chan_lsb_p +: cw];
    assign sel_valid = {1'b0, sel} < chan_lim;

    always_comb begin
        full_sel = 1'b0;
        for (int unsigned c = 0; c < channels_p; c++)
            if (sel == cw'(c)) full_sel = full[c];
    end

    assign fsb_ready_o = en_i & ~(sel_valid & full_sel);
    assign accept      = fsb_v_i & fsb_ready_o;
    assign drop        = accept & ~sel_valid;

    always_comb begin
        enq = '0;
        for (int unsigned c = 0; c < channels_p; c++)
            enq[c] = accept & (sel == cw'(c));
    end

    genvar c;
    for (c = 0; c < channels_p; c++) begin : g_q
        logic [width_p-1:0] mem [fifo_els_p];
        logic [pw-1:0]      rd_ptr, wr_ptr;
        logic [nw-1:0]      count;
        logic               deq;

        assign full[c]     = count == nw'(fifo_els_p);
        assign node_v_o[c] = count != '0;
        assign deq         = node_yumi_i[c] & node_v_o[c];
        assign node_data_o[c*width_p +: width_p] = mem[rd_ptr];

        always_ff @(posedge clk_i)
            if (enq[c]) mem[wr_ptr] <= fsb_data_i;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq[c]) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
                if (deq)    rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
                if (enq[c] & ~deq)      count <= count + 1'b1;
                else if (~enq[c] & deq) count <= count - 1'b1;
            end
        end
    end

    logic [cw-1:0]         ptr, gnt, idx;
    logic [channels_p-1:0] gnt_oh;
    logic                  found, load;
    logic [width_p-1:0]    load_data;

    // Rotating search starting just after the last granted channel.
    always_comb begin
        gnt    = '0;
        gnt_oh = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= channels_p; i++) begin
            idx = cw'((32'(ptr) + i) % channels_p);
            if (!found && node_v_i[idx]) begin
                found       = 1'b1;
                gnt         = idx;
                gnt_oh[idx] = 1'b1;
            end
        end
    end

    assign load        = en_i & found & (credits_o != '0) & (~fsb_v_o | fsb_yumi_i);
    assign node_yumi_o = load ? gnt_oh : '0;
    assign overflow    = credit_v_i & ~load & (credits_o == cred_max);

    always_comb begin
        load_data = node_data_i[gnt*width_p +: width_p];
        load_data[chan_lsb_p +: cw] = gnt;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fsb_v_o    <= 1'b0;
            fsb_data_o <= '0;
            ptr        <= cw'(channels_p - 1);
            credits_o  <= cred_max;
            err_o      <= 1'b0;
        end else begin
            if (load) begin
                fsb_v_o    <= 1'b1;
                fsb_data_o <= load_data;
                ptr        <= gnt;
            end else if (fsb_yumi_i) begin
                fsb_v_o <= 1'b0;
            end
            if (load & ~credit_v_i)
                credits_o <= credits_o - 1'b1;
            else if (credit_v_i & ~load & ~overflow)
                credits_o <= credits_o + 1'b1;
            if (drop | overflow) err_o <= 1'b1;
        end
    end

`ifdef BSG_FSB_CLIENT_STATS_EN
    logic [31:0] rx_cnt, tx_cnt, stall_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) rx_cnt <= rx_cnt + 1'b1;
            if (load)   tx_cnt <= tx_cnt + 1'b1;
            if (|node_v_i & en_i & (credits_o == '0)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stat_rx_o    = rx_cnt;
    assign stat_tx_o    = tx_cnt;
    assign stat_stall_o = stall_cnt;
`else
    assign stat_rx_o    = '0;
    assign stat_tx_o    = '0;
    assign stat_stall_o = '0;
`endif

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (node_yumi_i & ~node_v_o) == '0);

endmodule
